// File: rtl/branch_predictor_update.sv
// Dual-bank direct-mapped BTB with 2-bit counters; one 8-byte fetch packet per lookup.
// Optional BPU_STAT_EN adds update/mispredict statistic counters.
module branch_predictor_update #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic        pred_slot,
  output logic [31:0] pred_target,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_type,
  input  logic        upd_jump,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict
`ifdef BPU_STAT_EN
  ,
  output logic [31:0] stat_upd_cnt,
  output logic [31:0] stat_mis_cnt
`endif
);

  localparam int NUM_ENT = 1 << IDX_W;
  localparam int TAG_LO  = IDX_W + 3;

  logic             upd_active;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       slot_taken;
  logic [1:0][31:0] slot_target;

  assign upd_active = (upd_type != 2'b00);
  assign upd_idx    = upd_pc[IDX_W+2:3];
  assign upd_tag    = upd_pc[TAG_LO +: TAG_W];
  assign rd_idx     = if_pc[IDX_W+2:3];
  assign rd_tag     = if_pc[TAG_LO +: TAG_W];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic             valid_reg  [NUM_ENT];
    logic [TAG_W-1:0] tag_reg    [NUM_ENT];
    logic [1:0]       typ_reg    [NUM_ENT];
    logic [29:0]      target_reg [NUM_ENT];
    logic [1:0]       ctr_reg    [NUM_ENT];
    logic             upd_sel;
    logic             upd_hit;
    logic [1:0]       ctr_cur;
    logic             rd_hit;

    assign upd_sel = upd_active && (upd_pc[2] == 1'(gi));
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
    assign ctr_cur = ctr_reg[upd_idx];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < NUM_ENT; i++) begin
          valid_reg[i] <= 1'b0;
          ctr_reg[i]   <= 2'd0;
        end
      end else if (upd_sel) begin
        if (upd_hit) begin
          if (upd_type == 2'b01) begin
            if (upd_jump) begin
              ctr_reg[upd_idx]    <= (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
              target_reg[upd_idx] <= upd_target[31:2];
            end else begin
              ctr_reg[upd_idx] <= (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;
            end
          end else begin
            ctr_reg[upd_idx]    <= 2'd3;
            target_reg[upd_idx] <= upd_target[31:2];
            typ_reg[upd_idx]    <= upd_type;
          end
        end else if (upd_jump) begin
          valid_reg[upd_idx]  <= 1'b1;
          tag_reg[upd_idx]    <= upd_tag;
          typ_reg[upd_idx]    <= upd_type;
          target_reg[upd_idx] <= upd_target[31:2];
          ctr_reg[upd_idx]    <= (upd_type == 2'b01) ? 2'd2 : 2'd3;
        end
      end
    end

    // Lookup sees the table before this cycle's update lands (read-first).
    assign rd_hit          = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);
    assign slot_taken[gi]  = rd_hit && ((typ_reg[rd_idx] != 2'b01) || ctr_reg[rd_idx][1]);
    assign slot_target[gi] = {target_reg[rd_idx], 2'b00};
  end

  logic        pred_valid_reg;
  logic        pred_taken_reg;
  logic        pred_slot_reg;
  logic [31:0] pred_target_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_slot_reg   <= 1'b0;
      pred_target_reg <= 32'd0;
    end else if (!if_stall) begin
      if (if_req) begin
        pred_valid_reg  <= 1'b1;
        pred_taken_reg  <= slot_taken[0] | slot_taken[1];
        pred_slot_reg   <= ~slot_taken[0];
        pred_target_reg <= slot_taken[0] ? slot_target[0] :
                           slot_taken[1] ? slot_target[1] : 32'd0;
      end else begin
        pred_valid_reg <= 1'b0;
      end
    end
  end

  assign pred_valid  = pred_valid_reg;
  assign pred_taken  = pred_taken_reg;
  assign pred_slot   = pred_slot_reg;
  assign pred_target = pred_target_reg;

`ifdef BPU_STAT_EN
  logic [31:0] stat_upd_reg;
  logic [31:0] stat_mis_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_upd_reg <= 32'd0;
      stat_mis_reg <= 32'd0;
    end else if (upd_active) begin
      stat_upd_reg <= stat_upd_reg + 32'd1;
      if (upd_mispredict) begin
        stat_mis_reg <= stat_mis_reg + 32'd1;
      end
    end
  end

  assign stat_upd_cnt = stat_upd_reg;
  assign stat_mis_cnt = stat_mis_reg;

  logic unused_bits;
  assign unused_bits = ^{if_pc[2:0], if_pc[31:TAG_LO+TAG_W], upd_pc[1:0],
                         upd_pc[31:TAG_LO+TAG_W], upd_target[1:0]};
`else
  // Untagged PC bits alias by design; mispredict only feeds the statistics.
  logic unused_bits;
  assign unused_bits = ^{if_pc[2:0], if_pc[31:TAG_LO+TAG_W], upd_pc[1:0],
                         upd_pc[31:TAG_LO+TAG_W], upd_target[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_update.sv
// Self-checking bench: directed steps plus random traffic against a table-level model.
module tb_branch_predictor_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        pred_valid;
  logic        pred_taken;
  logic        pred_slot;
  logic [31:0] pred_target;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_jump;
  logic [31:0] upd_target;
  logic        upd_mispredict;
`ifdef BPU_STAT_EN
  logic [31:0] stat_upd_cnt;
  logic [31:0] stat_mis_cnt;
`endif

  always #5 clk = ~clk;

  branch_predictor_update #(.IDX_W(5), .TAG_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_pc          (if_pc),
    .if_stall       (if_stall),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_slot      (pred_slot),
    .pred_target    (pred_target),
    .upd_pc         (upd_pc),
    .upd_type       (upd_type),
    .upd_jump       (upd_jump),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict)
`ifdef BPU_STAT_EN
    ,
    .stat_upd_cnt   (stat_upd_cnt),
    .stat_mis_cnt   (stat_mis_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: a table of branch records per (bank, index), updated by the training rules.
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned typ;
    int unsigned tgt;
    int unsigned ctr;
  } ent_t;

  ent_t        tbl [2][32];
  bit          e_valid;
  bit          e_taken;
  bit          e_slot;
  int unsigned e_target;
  int unsigned e_upd;
  int unsigned e_mis;

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc >> 3) & 32'h1F;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc >> 8) & 32'hFF;
  endfunction

  function automatic bit slot_predicts(input int b, input logic [31:0] pc);
    ent_t e;
    e = tbl[b][f_idx(pc)];
    return e.v && e.tag == f_tag(pc) && (e.typ != 1 || e.ctr >= 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit req, input bit stall, input logic [31:0] pc,
                      input logic [1:0] ut, input logic [31:0] upc, input bit j,
                      input logic [31:0] tgt, input bit mis);
    int unsigned b, i, t;
    bit          hit, t0, t1;
    rst = r; if_req = req; if_stall = stall; if_pc = pc;
    upd_type = ut; upd_pc = upc; upd_jump = j; upd_target = tgt; upd_mispredict = mis;
    if (r) begin
      for (int bb = 0; bb < 2; bb++)
        for (int ii = 0; ii < 32; ii++) begin
          tbl[bb][ii].v   = 0;
          tbl[bb][ii].ctr = 0;
        end
      e_valid = 0; e_taken = 0; e_slot = 0; e_target = 0; e_upd = 0; e_mis = 0;
    end else begin
      if (!stall) begin
        if (req) begin
          t0 = slot_predicts(0, pc);
          t1 = slot_predicts(1, pc);
          e_valid  = 1;
          e_taken  = t0 | t1;
          e_slot   = !t0;
          e_target = t0 ? tbl[0][f_idx(pc)].tgt : (t1 ? tbl[1][f_idx(pc)].tgt : 0);
        end else begin
          e_valid = 0;
        end
      end
      if (ut != 0) begin
        e_upd++;
        if (mis) e_mis++;
        b = upc[2]; i = f_idx(upc); t = f_tag(upc);
        hit = tbl[b][i].v && tbl[b][i].tag == t;
        if (hit && ut == 1) begin
          if (j) begin
            tbl[b][i].ctr = (tbl[b][i].ctr < 3) ? tbl[b][i].ctr + 1 : 3;
            tbl[b][i].tgt = tgt & ~32'h3;
          end else begin
            tbl[b][i].ctr = (tbl[b][i].ctr > 0) ? tbl[b][i].ctr - 1 : 0;
          end
        end else if (hit) begin
          tbl[b][i].ctr = 3;
          tbl[b][i].tgt = tgt & ~32'h3;
          tbl[b][i].typ = ut;
        end else if (j) begin
          tbl[b][i].v   = 1;
          tbl[b][i].tag = t;
          tbl[b][i].typ = ut;
          tbl[b][i].tgt = tgt & ~32'h3;
          tbl[b][i].ctr = (ut == 1) ? 2 : 3;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_valid});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
    chk("pred_slot", {31'd0, pred_slot}, {31'd0, e_slot});
    chk("pred_target", pred_target, e_target);
`ifdef BPU_STAT_EN
    chk("stat_upd_cnt", stat_upd_cnt, e_upd);
    chk("stat_mis_cnt", stat_mis_cnt, e_mis);
`endif
    $display("step rst=%0d req=%0d stall=%0d pc=%h upd=%0d/%h j=%0d -> v=%0d t=%0d s=%0d tgt=%h",
             r, req, stall, pc, ut, upc, j, pred_valid, pred_taken, pred_slot, pred_target);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(0, 1, 0, pc, 2'b00, 32'd0, 0, 32'd0, 0);
  endtask

  task automatic update(input logic [31:0] upc, input logic [1:0] ut, input bit j,
                        input logic [31:0] tgt, input bit mis);
    step(0, 0, 0, 32'd0, ut, upc, j, tgt, mis);
  endtask

  logic [31:0] rpc, rupc;

  initial begin
    step(1, 0, 0, 32'd0, 2'b00, 32'd0, 0, 32'd0, 0);
    step(1, 0, 0, 32'd0, 2'b00, 32'd0, 0, 32'd0, 0);

    // Cold lookup misses
    lookup(32'h1C000000);
    // Conditional taken in slot1 allocates with ctr=2
    update(32'h1C000004, 2'b01, 1, 32'h1C000100, 1);
    lookup(32'h1C000000);
    // Two not-taken updates drop below the taken threshold; one taken brings it to 1
    update(32'h1C000004, 2'b01, 0, 32'h0, 1);
    update(32'h1C000004, 2'b01, 0, 32'h0, 0);
    lookup(32'h1C000000);
    update(32'h1C000004, 2'b01, 1, 32'h1C000100, 0);
    lookup(32'h1C000000);
    // Both slots taken: slot0 wins
    update(32'h1C000040, 2'b10, 1, 32'h1C000200, 0);
    update(32'h1C000044, 2'b01, 1, 32'h1C000300, 0);
    update(32'h1C000044, 2'b01, 1, 32'h1C000300, 0);
    lookup(32'h1C000040);
    // Same-cycle lookup and allocate: lookup sees old contents
    step(0, 1, 0, 32'h1C000080, 2'b10, 32'h1C000080, 1, 32'h1C000400, 0);
    lookup(32'h1C000080);
    // Stall holds outputs while if_pc changes; update still lands
    step(0, 1, 1, 32'h1C000040, 2'b00, 32'd0, 0, 32'd0, 0);
    step(0, 1, 1, 32'h1C000000, 2'b11, 32'h1C0000C0, 1, 32'h1C000500, 1);
    step(0, 0, 1, 32'h1C0000C0, 2'b00, 32'd0, 0, 32'd0, 0);
    lookup(32'h1C0000C0);
    // Not-taken miss must not allocate
    update(32'h1C000100, 2'b01, 0, 32'h1C000600, 0);
    update(32'h1C000100, 2'b01, 0, 32'h1C000600, 0);
    lookup(32'h1C000100);
    // Idle request clears pred_valid
    step(0, 0, 0, 32'h1C000040, 2'b00, 32'd0, 0, 32'd0, 0);
    // Reset with an update present: update dropped, table empty afterwards
    step(1, 1, 0, 32'h1C000040, 2'b10, 32'h1C000140, 1, 32'h1C000700, 1);
    lookup(32'h1C000040);
    lookup(32'h1C000000);
    lookup(32'h1C000140);
    // Five updates, two flagged as mispredicts
    update(32'h1C000008, 2'b01, 1, 32'h1C000800, 1);
    update(32'h1C000008, 2'b01, 0, 32'h0, 0);
    update(32'h1C00000C, 2'b10, 1, 32'h1C000900, 1);
    update(32'h1C000010, 2'b11, 0, 32'h0, 0);
    update(32'h1C000014, 2'b01, 1, 32'h1C000A00, 0);
    lookup(32'h1C000008);

    // Random traffic over a small PC window so entries collide and hit often
    for (int n = 0; n < 400; n++) begin
      rpc  = 32'h1C000000 | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 3)
           | ($urandom_range(0, 7) == 0 ? 32'h00100000 : 32'h0);
      rupc = 32'h1C000000 | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 3)
           | ($urandom_range(0, 1) << 2);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           rpc, 2'($urandom_range(0, 3)), rupc, 1'($urandom_range(0, 1)),
           32'h1C000000 | ($urandom & 32'h0000FFFF), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_update.md
Name: branch_predictor_update

Overview:
- Branch predictor consumed by fetch; trained by the MEM-stage branch resolution outputs (pc_of_br, pd_type, br_target, br_jump) of the EX->MEM pipeline register.
- Dual-bank direct-mapped BTB with a 2-bit counter per entry; bank selected by pc[2], so one 8-byte-aligned fetch packet (2 slots) is predicted per cycle.
- Prediction output is registered: 1-cycle latency after the lookup request.
- Flop-based tables; no SRAM macros.

Parameters:
- IDX_W, 5, index bits per bank (2^IDX_W entries per bank).
- TAG_W, 8, tag bits: pc[IDX_W+3 +: TAG_W].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  lookup request this cycle.
- if_pc  in  32  fetch packet PC, 8-byte aligned (pc[2:0] ignored).
- if_stall  in  1  hold prediction outputs; ignore if_req/if_pc.
- pred_valid  out  1  pred_* outputs correspond to the last accepted request.
- pred_taken  out  1  packet predicted to redirect.
- pred_slot  out  1  0 = slot0 (pc) redirects, 1 = slot1 (pc+4).
- pred_target  out  32  redirect target.
- upd_pc  in  32  PC of resolved branch (MEM_pc_of_br).
- upd_type  in  2  00 none, 01 conditional, 10 direct unconditional, 11 indirect (MEM_pd_type; already gated by stall/flush upstream).
- upd_jump  in  1  branch actually taken (MEM_br_jump).
- upd_target  in  32  actual target (MEM_br_target).
- upd_mispredict  in  1  resolution corrected the prediction (MEM_br); used only by the optional feature.

Behaviour:
- Entry fields: valid, tag[TAG_W], type[2], target[30] (target[1:0] = 00), ctr[2].
- Update:
  - Active when upd_type != 00.
  - Bank = upd_pc[2], index = upd_pc[IDX_W+2:3].
  - Hit = valid & tag match.
  - Hit, type 01: ctr saturating +1 if upd_jump, -1 otherwise (range 0..3); if upd_jump, overwrite target.
  - Hit, type 10/11: ctr forced to 3, target overwritten, type overwritten.
  - Miss with upd_jump = 1: allocate. valid = 1, tag and type written, target written, ctr = 2 for type 01, 3 otherwise.
  - Miss with upd_jump = 0: no write.
- Update timing and priority:
  - Write takes effect at the next clk edge.
  - Update is never blocked by if_stall.
- Lookup:
  - On clk edge with if_req & ~if_stall, read both banks at index if_pc[IDX_W+2:3] and register the results.
  - slotN hit = valid & tag match against if_pc.
  - slotN taken = hit & (type != 01 | ctr[1]).
  - pred_taken = slot0 taken | slot1 taken.
  - pred_slot = ~slot0 taken (slot0 has priority; slot1 is ignored if slot0 is taken).
  - pred_target = target of the selected slot, or 0 when not taken.
- pred_valid:
  - Set to 1 on each accepted request.
  - Set to 0 on a cycle with ~if_req & ~if_stall.
  - Held during if_stall.
- Read/write collision:
  - Same bank and index updated in the same cycle as a lookup: lookup returns pre-update contents (read-first, no bypass).
- Stall: while if_stall = 1, all pred_* outputs hold their values.
- Reset:
  - All valid bits and all ctr values are cleared to 0.
  - pred_valid = 0, pred_taken = 0, pred_slot = 0, pred_target = 0.
  - Reset has priority over concurrent update and lookup; an update presented in the reset cycle is dropped.
- Aliasing: untagged PC bits above the tag field alias; this is accepted (prediction only).

Optional Feature:
- Macro: BPU_STAT_EN.
- With the macro defined: adds outputs stat_upd_cnt[31:0] and stat_mis_cnt[31:0].
  - stat_upd_cnt increments on each active update.
  - stat_mis_cnt increments when an active update has upd_mispredict = 1.
  - Both wrap at 2^32 and are cleared by rst.
- Without the macro: no counter ports, no counter logic.

Test Plan:
1. Reset, then lookup if_pc=0x1C000000 -> next cycle: pred_valid=1, pred_taken=0, pred_target=0.
2. Update upd_pc=0x1C000004, upd_type=01, upd_jump=1, upd_target=0x1C000100; then lookup 0x1C000000 -> pred_taken=1, pred_slot=1, pred_target=0x1C000100, ctr=2.
3. Same entry with two not-taken updates (ctr 2->1->0), then lookup -> pred_taken=0; one taken update (ctr=1) -> still pred_taken=0.
4. Entries in both slots (slot0 type 10 -> 0x1C000200; slot1 conditional ctr=3) -> pred_slot=0, pred_target=0x1C000200.
5. Lookup and update to the same index in the same cycle (new allocate) -> lookup returns miss; a repeat lookup next cycle returns a hit. if_stall=1 for 3 cycles with a changing if_pc -> outputs unchanged.
6. Assert rst mid-stream with an update present -> all entries invalid afterwards; stat counters = 0 (with BPU_STAT_EN). After 5 updates, 2 of them with upd_mispredict=1 -> stat_upd_cnt=5, stat_mis_cnt=2.
